// File: rtl/sr_latch_driver_pkg.sv
// Purpose: shared FSM state encodings and default timing for the SR latch driver.
// Latency: none, constants only.
// Backpressure: none.
package sr_latch_driver_pkg;

  // FSM state encodings, 2-bit for compatibility with older tooling
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE_S = 2'd1;
  localparam logic [1:0] ST_DRIVE_R = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  // Simulation-friendly defaults; the board build uses DEBOUNCE_CYCLES=1_000_000
  localparam int DEBOUNCE_CYCLES_DEF = 4;
  localparam int CNT_W_DEF           = 20;
  localparam int PULSE_LEN_DEF       = 3;

endpackage

// File: rtl/sr_latch_driver_debounce_sync.sv
// Purpose: 2-flop synchroniser followed by a stable-level debouncer for one button.
// Latency: level changes 2 + DEBOUNCE_CYCLES edges after the raw input changes.
// Backpressure: none; a change shorter than DEBOUNCE_CYCLES is never accepted.
module debounce_sync
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;

  // Synchronise the raw button, then count consecutive cycles it disagrees with the accepted level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;

endmodule

// File: rtl/sr_latch_driver.sv
// Purpose: turns debounced set/reset presses into timed E/S or E/R pulses, never S and R together.
// Latency: pulse starts 2 edges after the debounced rise; commands spaced PULSE_LEN+2 cycles.
// Backpressure: presses during a pulse or gap wait in pending flags; simultaneous requests are dropped with conflict.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int PULSE_LEN       = PULSE_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic E,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict
);

  localparam int             PW         = $clog2(PULSE_LEN + 1);
  localparam logic [PW-1:0]  PULSE_LAST = PW'(PULSE_LEN - 1);

  logic          w_set_lvl;
  logic          w_rst_lvl;
  logic          w_set_rise;
  logic          w_rst_rise;
  logic          w_idle;
  logic          w_conflict;
  logic          w_take_set;
  logic          w_take_rst;

  logic          r_set_lvl_d;
  logic          r_rst_lvl_d;
  logic          r_set_p;
  logic          r_rst_p;
  logic [1:0]    r_state;
  logic [PW-1:0] r_cnt;
  logic          r_e;
  logic          r_s;
  logic          r_r;
  logic          r_conflict;

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_set (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_set),
    .level (w_set_lvl)
  );

  debounce_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_db_rst (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_rst),
    .level (w_rst_lvl)
  );

  // Only presses (0->1) make commands; releases are ignored
  assign w_set_rise = w_set_lvl & ~r_set_lvl_d;
  assign w_rst_rise = w_rst_lvl & ~r_rst_lvl_d;

  // Pending flags are only consumed while idle
  assign w_idle     = (r_state == ST_IDLE);
  assign w_conflict = w_idle & r_set_p & r_rst_p;
  assign w_take_set = w_idle & r_set_p & ~r_rst_p;
  assign w_take_rst = w_idle & r_rst_p & ~r_set_p;

  // Edge detect history and pending flags; a rise on the consuming edge survives the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_set_lvl_d <= 1'b0;
      r_rst_lvl_d <= 1'b0;
      r_set_p     <= 1'b0;
      r_rst_p     <= 1'b0;
    end else begin
      r_set_lvl_d <= w_set_lvl;
      r_rst_lvl_d <= w_rst_lvl;
      r_set_p     <= (r_set_p & ~(w_conflict | w_take_set)) | w_set_rise;
      r_rst_p     <= (r_rst_p & ~(w_conflict | w_take_rst)) | w_rst_rise;
    end
  end

  // Command FSM with registered drive outputs, loaded on the same edge as the state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_e        <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_conflict) begin
            r_conflict <= 1'b1;
          end else if (w_take_set) begin
            r_state <= ST_DRIVE_S;
            r_cnt   <= PULSE_LAST;
            r_e     <= 1'b1;
            r_s     <= 1'b1;
            r_r     <= 1'b0;
          end else if (w_take_rst) begin
            r_state <= ST_DRIVE_R;
            r_cnt   <= PULSE_LAST;
            r_e     <= 1'b1;
            r_s     <= 1'b0;
            r_r     <= 1'b1;
          end
        end
        ST_DRIVE_S, ST_DRIVE_R: begin
          if (r_cnt == '0) begin
            r_state <= ST_GAP;
            r_e     <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_e     <= 1'b0;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
        end
      endcase
    end
  end

  assign E        = r_e;
  assign S        = r_s;
  assign R        = r_r;
  assign busy     = (r_state != ST_IDLE);
  assign conflict = r_conflict;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Purpose: scoreboard bench for sr_latch_driver with DEBOUNCE_CYCLES=4, PULSE_LEN=3.
// Latency: expected pulse start = press cycle + 8 (2 sync, 4 debounce, flag, FSM), or queued behind the previous command.
// Backpressure: queued commands start PULSE_LEN+2 cycles after the previous one.
module tb_sr_latch_driver;

  localparam int PL  = 3;
  localparam int LAT = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_set;
  logic btn_rst;
  logic E, S, R, busy, conflict;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (20),
    .PULSE_LEN       (PL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_set  (btn_set),
    .btn_rst  (btn_rst),
    .E        (E),
    .S        (S),
    .R        (R),
    .busy     (busy),
    .conflict (conflict)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int kind;   // 1 = set pulse, 0 = reset pulse
    int len;
    int start;
  } pulse_t;

  pulse_t exp_q[$];
  int     conf_q[$];
  int     next_free = 0;

  // Expected pulse for a press driven now, queued behind any earlier command
  task automatic press_expect(input int kind);
    int st;
    st = cyc + LAT;
    if (st < next_free) st = next_free;
    exp_q.push_back('{kind, PL, st});
    next_free = st + PL + 2;
  endtask

  // Monitor: reconstruct pulses, track a gated SR latch, count invariant violations
  int     in_pulse = 0;
  int     p_kind   = 0;
  int     p_len    = 0;
  int     p_start  = 0;
  int     viol     = 0;
  logic   q_latch  = 1'b0;
  pulse_t e_p;

  always @(negedge clk) begin
    if ((S && R) || ((S || R) && !E) || (E && !busy)) viol++;
    if (E && S) q_latch = 1'b1;
    else if (E && R) q_latch = 1'b0;
    if (E) begin
      if (in_pulse == 0) begin
        in_pulse = 1;
        p_kind   = S ? 1 : 0;
        p_len    = 1;
        p_start  = cyc;
      end else begin
        p_len++;
        if ((S ? 1 : 0) != p_kind) viol++;
      end
    end else if (in_pulse != 0) begin
      in_pulse = 0;
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", p_start, -1);
      end else begin
        e_p = exp_q.pop_front();
        chk("pulse_kind",  p_kind,  e_p.kind);
        chk("pulse_len",   p_len,   e_p.len);
        chk("pulse_start", p_start, e_p.start);
      end
    end
    if (conflict) begin
      if (conf_q.size() == 0) chk("unexpected_conflict", cyc, -1);
      else chk("conflict_cycle", cyc, conf_q.pop_front());
    end
  end

  int c0;
  int bpat[6] = '{1, 1, 0, 1, 0, 0};

  initial begin
    rst_n   = 1'b0;
    btn_set = 1'b1;
    btn_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_E", E, 0);
    chk("rst_S", S, 0);
    chk("rst_R", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conflict", conflict, 0);

    // Button already held when reset releases: accepted after sync + debounce
    rst_n = 1'b1;
    press_expect(1);
    repeat (10) @(negedge clk);
    btn_set = 1'b0;
    repeat (25) @(negedge clk);
    chk("latch_q_after_reset_press", q_latch, 1);

    // Bouncy reset button, then a clean hold
    for (int i = 0; i < 6; i++) begin
      btn_rst = bpat[i][0];
      @(negedge clk);
    end
    btn_rst = 1'b1;
    press_expect(0);
    repeat (6) @(negedge clk);
    btn_rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("latch_q_after_bounce_rst", q_latch, 0);

    // Clean set press held 10 cycles
    btn_set = 1'b1;
    press_expect(1);
    repeat (10) @(negedge clk);
    btn_set = 1'b0;
    repeat (25) @(negedge clk);
    chk("latch_q_after_set", q_latch, 1);
    chk("idle_busy_after_set", busy, 0);

    // Simultaneous presses: one conflict pulse, no drive, never busy
    btn_set = 1'b1;
    btn_rst = 1'b1;
    c0 = cyc;
    conf_q.push_back(c0 + LAT);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) begin
        btn_set = 1'b0;
        btn_rst = 1'b0;
      end
      if (cyc == c0 + LAT || cyc == c0 + LAT + 1) begin
        chk("conflict_busy", busy, 0);
        chk("conflict_E", E, 0);
      end
    end
    repeat (25) @(negedge clk);

    // Reset press debounced while the set pulse is driving: queued behind it
    btn_set = 1'b1;
    press_expect(1);
    repeat (2) @(negedge clk);
    btn_rst = 1'b1;
    press_expect(0);
    repeat (8) @(negedge clk);
    btn_set = 1'b0;
    btn_rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("latch_q_after_queued", q_latch, 0);

    // Reset during the 2nd cycle of DRIVE_S truncates the pulse to 2 cycles
    btn_set = 1'b1;
    c0 = cyc;
    exp_q.push_back('{1, 2, c0 + LAT});
    repeat (6) @(negedge clk);
    btn_set = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_E", E, 0);
    chk("midrst_S", S, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    chk("pulses_outstanding", exp_q.size(), 0);
    chk("conflicts_outstanding", conf_q.size(), 0);
    chk("invariant_violations", viol, 0);
    chk("pulse_open_at_end", in_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
